// File: rtl/demux_pkg.sv
// demux_pkg -- shared widths and buffer occupancy encoding for stream_demux_1to2.
// Rev 1.0
`default_nettype none

package demux_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;
endpackage

`default_nettype wire

// File: rtl/demux_out_buf.sv
// demux_out_buf -- 2-entry elastic output buffer; head is always the registered output.
// Rev 1.0
`default_nettype none

module demux_out_buf
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data
);

  occ_t              occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              pop;

  assign pop   = valid & ready;
  assign full  = (occ_q == OCC_TWO);
  assign valid = (occ_q != OCC_EMPTY);
  assign data  = head_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          occ_d  = OCC_ONE;
          head_d = push_data;
        end
      end
      OCC_ONE: begin
        case ({push, pop})
          2'b10: begin
            occ_d  = OCC_TWO;
            tail_d = push_data;
          end
          2'b01: occ_d = OCC_EMPTY;
          // Head leaves and the incoming beat takes its place in one cycle.
          2'b11: head_d = push_data;
          default: ;
        endcase
      end
      OCC_TWO: begin
        if (pop) begin
          occ_d  = OCC_ONE;
          head_d = tail_q;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2 -- routes a valid/ready byte stream to port A (sel=1) or B (sel=0).
// Rev 1.0
`default_nettype none

module stream_demux_1to2
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sel,
  input  logic [DATA_W-1:0] s_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);

  logic             full_a, full_b;
  logic             push_a, push_b;
  logic [CNT_W-1:0] a_cnt_q, b_cnt_q;

  // Ready looks only at registered full flags, never at the consumers' ready.
  assign s_ready = rst_n & ~(s_sel ? full_a : full_b);
  assign push_a  = s_valid & s_ready & s_sel;
  assign push_b  = s_valid & s_ready & ~s_sel;

  demux_out_buf #(.DATA_W(DATA_W)) u_buf_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_a),
    .push_data (s_data),
    .full      (full_a),
    .valid     (a_valid),
    .ready     (a_ready),
    .data      (a_data)
  );

  demux_out_buf #(.DATA_W(DATA_W)) u_buf_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_b),
    .push_data (s_data),
    .full      (full_b),
    .valid     (b_valid),
    .ready     (b_ready),
    .data      (b_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (push_a) a_cnt_q <= a_cnt_q + CNT_W'(1);
      if (push_b) b_cnt_q <= b_cnt_q + CNT_W'(1);
    end
  end

  assign a_count = a_cnt_q;
  assign b_count = b_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2 -- scoreboard bench: driver queues expected beats, monitor pops on output handshakes.
// Rev 1.0
`default_nettype none

module tb_stream_demux_1to2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_sel = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        a_ready = 1'b0;
  logic        b_ready = 1'b0;
  logic        s_ready, a_valid, b_valid;
  logic [7:0]  a_data, b_data;
  logic [15:0] a_count, b_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [15:0] exp_a_cnt = 16'd0;
  logic [15:0] exp_b_cnt = 16'd0;
  bit          rand_mode = 1'b0;

  stream_demux_1to2 #(.DATA_W(8), .CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_data  (b_data),
    .a_count (a_count),
    .b_count (b_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic sel, input logic [7:0] d, output int waits);
    bit done;
    waits = 0;
    done = 1'b0;
    s_valid = 1'b1;
    s_sel = sel;
    s_data = d;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        done = 1'b1;
        if (sel) begin
          qa.push_back(d);
          exp_a_cnt = exp_a_cnt + 16'd1;
        end else begin
          qb.push_back(d);
          exp_b_cnt = exp_b_cnt + 16'd1;
        end
      end else begin
        waits++;
        if (waits > 1000) begin
          chk("send_timeout", 32'(waits), 32'd0);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      a_ready = ($urandom_range(0, 3) != 0);
      b_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares each output handshake against the queue and checks stability under stall.
  initial begin
    bit         a_hold, b_hold;
    logic [7:0] a_hold_d, b_hold_d;
    a_hold = 1'b0;
    b_hold = 1'b0;
    a_hold_d = 8'h00;
    b_hold_d = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        a_hold = 1'b0;
        b_hold = 1'b0;
      end else begin
        if (a_hold) begin
          chk("a_stall_valid", 32'(a_valid), 32'd1);
          chk("a_stall_data", 32'(a_data), 32'(a_hold_d));
        end
        if (b_hold) begin
          chk("b_stall_valid", 32'(b_valid), 32'd1);
          chk("b_stall_data", 32'(b_data), 32'(b_hold_d));
        end
        if (a_valid && a_ready) begin
          if (qa.size() == 0) chk("a_unexpected_beat", 32'(qa.size()), 32'd1);
          else chk("a_data", 32'(a_data), 32'(qa.pop_front()));
        end
        if (b_valid && b_ready) begin
          if (qb.size() == 0) chk("b_unexpected_beat", 32'(qb.size()), 32'd1);
          else chk("b_data", 32'(b_data), 32'(qb.pop_front()));
        end
        a_hold = a_valid && !a_ready;
        a_hold_d = a_data;
        b_hold = b_valid && !b_ready;
        b_hold_d = b_data;
      end
    end
  end

  initial begin
    int w;
    int stalls;
    int guard;

    // Power-on reset state
    s_valid = 1'b1;
    s_sel = 1'b0;
    #12;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_a_count", 32'(a_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_valid = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;

    // Routing and one-cycle latency
    send(1'b1, 8'h11, w);
    chk("rt_a_valid", 32'(a_valid), 32'd1);
    chk("rt_a_data", 32'(a_data), 32'h11);
    send(1'b0, 8'h22, w);
    chk("rt_b_valid", 32'(b_valid), 32'd1);
    chk("rt_b_data", 32'(b_data), 32'h22);
    send(1'b1, 8'h33, w);
    chk("rt_a_data2", 32'(a_data), 32'h33);
    idle();
    drain();
    chk("rt_a_count", 32'(a_count), 32'd2);
    chk("rt_b_count", 32'(b_count), 32'd1);

    // Back-pressure on A
    a_ready = 1'b0;
    send(1'b1, 8'hA0, w);
    send(1'b1, 8'hA1, w);
    chk("bp_two_accepted_wait", 32'(w), 32'd0);
    fork
      send(1'b1, 8'hA2, w);
      begin
        repeat (4) @(negedge clk);
        chk("bp_s_ready_low", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        a_ready = 1'b1;
      end
    join
    chk("bp_a2_waited", 32'(w >= 4), 32'd1);
    idle();
    drain();
    chk("bp_a_count", 32'(a_count), 32'(exp_a_cnt));

    // Isolation: A full, B still flows
    a_ready = 1'b0;
    send(1'b1, 8'hC0, w);
    send(1'b1, 8'hC1, w);
    send(1'b0, 8'h5B, w);
    chk("iso_wait", 32'(w), 32'd0);
    chk("iso_b_valid", 32'(b_valid), 32'd1);
    chk("iso_b_data", 32'(b_data), 32'h5B);
    idle();
    a_ready = 1'b1;
    drain();

    // Simultaneous push/pop in ONE, then sustained throughput
    a_ready = 1'b0;
    send(1'b1, 8'h01, w);
    a_ready = 1'b1;
    send(1'b1, 8'h02, w);
    chk("pp_wait", 32'(w), 32'd0);
    chk("pp_a_data", 32'(a_data), 32'h02);
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      send(1'b1, 8'(i + 8'h40), w);
      stalls += w;
      if (!a_valid || a_data != 8'(i + 8'h40)) stalls++;
    end
    chk("tp_stalls", 32'(stalls), 32'd0);
    idle();
    drain();

    // Mid-stream reset with A holding two beats
    a_ready = 1'b0;
    send(1'b1, 8'hE1, w);
    send(1'b1, 8'hE2, w);
    s_valid = 1'b1;
    s_sel = 1'b0;
    s_data = 8'hEE;
    #3;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    exp_a_cnt = 16'd0;
    exp_b_cnt = 16'd0;
    #1;
    chk("mr_a_valid", 32'(a_valid), 32'd0);
    chk("mr_b_valid", 32'(b_valid), 32'd0);
    chk("mr_a_count", 32'(a_count), 32'd0);
    chk("mr_b_count", 32'(b_count), 32'd0);
    chk("mr_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("mr_s_ready_hold", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_valid = 1'b0;
    a_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mr_no_ghost", 32'(a_valid | b_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random-stall scoreboard run
    rand_mode = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), w);
    end
    idle();
    rand_mode = 1'b0;
    @(posedge clk);
    #2;
    a_ready = 1'b1;
    b_ready = 1'b1;
    drain();
    chk("rnd_a_count", 32'(a_count), 32'(exp_a_cnt));
    chk("rnd_b_count", 32'(b_count), 32'(exp_b_cnt));

    // B counter wrap
    guard = 0;
    while (exp_b_cnt != 16'd0 && guard < 70000) begin
      send(1'b0, guard[7:0], w);
      guard++;
    end
    idle();
    drain();
    chk("wrap_b_count_zero", 32'(b_count), 32'h0000);
    chk("wrap_b_count_model", 32'(b_count), 32'(exp_b_cnt));
    chk("wrap_a_count", 32'(a_count), 32'(exp_a_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
